// File: rtl/ysyx_23060191_mem_arbiter_pkg.sv
// ysyx_23060191_mem_arbiter_pkg: shared state encodings and master indices for the memory arbiter
package ysyx_23060191_mem_arbiter_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2,
    ARB_RESP = 2'd3
  } arb_state_e;
  localparam logic ARB_M_IFU = 1'b0;
  localparam logic ARB_M_LSU = 1'b1;
endpackage

// File: rtl/ysyx_23060191_mem_arbiter_rr_arb2.sv
// ysyx_23060191_rr_arb2: combinational 2-way round-robin grant, ties go to the master that was not last granted
module ysyx_23060191_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);
  assign gnt_valid = |req;
  assign gnt_idx   = &req ? ~last : req[1];
endmodule

// File: rtl/ysyx_23060191_mem_arbiter.sv
// ysyx_23060191_mem_arbiter: shares one memory slave port between IFU (m0) and LSU (m1), one transaction at a time
module ysyx_23060191_mem_arbiter
  import ysyx_23060191_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req_valid,
  output logic                m0_req_ready,
  input  logic [ADDR_W-1:0]   m0_req_addr,
  input  logic                m0_req_wen,
  input  logic [DATA_W-1:0]   m0_req_wdata,
  input  logic [DATA_W/8-1:0] m0_req_wstrb,
  output logic                m0_rsp_valid,
  input  logic                m0_rsp_ready,
  output logic [DATA_W-1:0]   m0_rsp_rdata,
  output logic                m0_rsp_err,
  input  logic                m1_req_valid,
  output logic                m1_req_ready,
  input  logic [ADDR_W-1:0]   m1_req_addr,
  input  logic                m1_req_wen,
  input  logic [DATA_W-1:0]   m1_req_wdata,
  input  logic [DATA_W/8-1:0] m1_req_wstrb,
  output logic                m1_rsp_valid,
  input  logic                m1_rsp_ready,
  output logic [DATA_W-1:0]   m1_rsp_rdata,
  output logic                m1_rsp_err,
  output logic                s_req_valid,
  input  logic                s_req_ready,
  output logic [ADDR_W-1:0]   s_req_addr,
  output logic                s_req_wen,
  output logic [DATA_W-1:0]   s_req_wdata,
  output logic [DATA_W/8-1:0] s_req_wstrb,
  input  logic                s_rsp_valid,
  output logic                s_rsp_ready,
  input  logic [DATA_W-1:0]   s_rsp_rdata,
  input  logic                s_rsp_err
);
  arb_state_e state, state_nx;
  logic last_grant, g, gnt_valid, gnt_idx, accept, in_resp;
  logic [ADDR_W-1:0] addr_q;
  logic wen_q, err_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [DATA_W/8-1:0] wstrb_q;

  ysyx_23060191_rr_arb2 u_arb (
    .req       ({m1_req_valid, m0_req_valid}),
    .last      (last_grant),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign accept  = (state == ARB_IDLE) & gnt_valid;
  assign in_resp = state == ARB_RESP;

  // next-state: each phase advances only on its own handshake
  always_comb begin
    state_nx = state;
    unique case (state)
      ARB_IDLE: state_nx = accept ? ARB_REQ : ARB_IDLE;
      ARB_REQ:  state_nx = s_req_ready ? ARB_WAIT : ARB_REQ;
      ARB_WAIT: state_nx = s_rsp_valid ? ARB_RESP : ARB_WAIT;
      ARB_RESP: state_nx = (g ? m1_rsp_ready : m0_rsp_ready) ? ARB_IDLE : ARB_RESP;
      default:  state_nx = ARB_IDLE;
    endcase
  end

  // state register; reset drops any in-flight transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nx;
  end

  // capture the granted request on acceptance and the slave response on its handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= ARB_M_LSU;
      g          <= ARB_M_IFU;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        last_grant <= gnt_idx;
        g          <= gnt_idx;
        addr_q     <= gnt_idx ? m1_req_addr  : m0_req_addr;
        wen_q      <= gnt_idx ? m1_req_wen   : m0_req_wen;
        wdata_q    <= gnt_idx ? m1_req_wdata : m0_req_wdata;
        wstrb_q    <= gnt_idx ? m1_req_wstrb : m0_req_wstrb;
      end
      if (s_rsp_ready & s_rsp_valid) begin
        rdata_q <= s_rsp_rdata;
        err_q   <= s_rsp_err;
      end
    end
  end

  assign m0_req_ready = accept & (gnt_idx == ARB_M_IFU);
  assign m1_req_ready = accept & (gnt_idx == ARB_M_LSU);
  assign s_req_valid  = state == ARB_REQ;
  assign s_req_addr   = addr_q;
  assign s_req_wen    = wen_q;
  assign s_req_wdata  = wdata_q;
  assign s_req_wstrb  = wstrb_q;
  assign s_rsp_ready  = state == ARB_WAIT;
  assign m0_rsp_valid = in_resp & (g == ARB_M_IFU);
  assign m1_rsp_valid = in_resp & (g == ARB_M_LSU);
  assign m0_rsp_rdata = m0_rsp_valid ? rdata_q : '0;
  assign m1_rsp_rdata = m1_rsp_valid ? rdata_q : '0;
  assign m0_rsp_err   = m0_rsp_valid & err_q;
  assign m1_rsp_err   = m1_rsp_valid & err_q;
endmodule

// File: tb/tb_ysyx_23060191_mem_arbiter.sv
// tb_ysyx_23060191_mem_arbiter: directed self-checking bench for the two-master memory arbiter
module tb_ysyx_23060191_mem_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic m0_req_valid = 0, m0_req_ready, m0_req_wen = 0, m0_rsp_valid, m0_rsp_ready = 1, m0_rsp_err;
  logic m1_req_valid = 0, m1_req_ready, m1_req_wen = 0, m1_rsp_valid, m1_rsp_ready = 1, m1_rsp_err;
  logic [31:0] m0_req_addr = 0, m0_req_wdata = 0, m0_rsp_rdata;
  logic [31:0] m1_req_addr = 0, m1_req_wdata = 0, m1_rsp_rdata;
  logic [3:0] m0_req_wstrb = 0, m1_req_wstrb = 0, s_req_wstrb;
  logic s_req_valid, s_req_ready = 1, s_req_wen, s_rsp_valid = 0, s_rsp_ready, s_rsp_err = 0;
  logic [31:0] s_req_addr, s_req_wdata, s_rsp_rdata = 0;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  ysyx_23060191_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_addr(m0_req_addr),
    .m0_req_wen(m0_req_wen), .m0_req_wdata(m0_req_wdata), .m0_req_wstrb(m0_req_wstrb),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready), .m0_rsp_rdata(m0_rsp_rdata), .m0_rsp_err(m0_rsp_err),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_addr(m1_req_addr),
    .m1_req_wen(m1_req_wen), .m1_req_wdata(m1_req_wdata), .m1_req_wstrb(m1_req_wstrb),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready), .m1_rsp_rdata(m1_rsp_rdata), .m1_rsp_err(m1_rsp_err),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_addr(s_req_addr), .s_req_wen(s_req_wen),
    .s_req_wdata(s_req_wdata), .s_req_wstrb(s_req_wstrb),
    .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready), .s_rsp_rdata(s_rsp_rdata), .s_rsp_err(s_rsp_err)
  );

  task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", t, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic xact(input logic g, input logic [31:0] ea, input logic [31:0] rd, input logic er, input string t);
    #1;
    chk({t, " req_ready granted"}, g ? m1_req_ready : m0_req_ready, 1);
    chk({t, " req_ready other"}, g ? m0_req_ready : m1_req_ready, 0);
    tick;
    chk({t, " s_req_valid"}, s_req_valid, 1);
    chk({t, " s_req_addr"}, s_req_addr, ea);
    chk({t, " ready blocked in REQ"}, {m1_req_ready, m0_req_ready}, 0);
    tick;
    chk({t, " s_rsp_ready"}, s_rsp_ready, 1);
    s_rsp_valid = 1; s_rsp_rdata = rd; s_rsp_err = er;
    tick;
    s_rsp_valid = 0; s_rsp_rdata = 0; s_rsp_err = 0;
    chk({t, " rsp_valid"}, {m1_rsp_valid, m0_rsp_valid}, g ? 2 : 1);
    chk({t, " rsp_rdata"}, g ? m1_rsp_rdata : m0_rsp_rdata, rd);
    chk({t, " rsp_err"}, g ? m1_rsp_err : m0_rsp_err, er);
    chk({t, " other rdata"}, g ? m0_rsp_rdata : m1_rsp_rdata, 0);
    tick;
    chk({t, " back to idle"}, {m1_rsp_valid, m0_rsp_valid, s_req_valid, s_rsp_ready}, 0);
  endtask

  initial begin
    #12;
    chk("reset s_req_valid", s_req_valid, 0);
    chk("reset s_rsp_ready", s_rsp_ready, 0);
    chk("reset rsp_valid", {m1_rsp_valid, m0_rsp_valid}, 0);
    chk("reset s_req_addr", s_req_addr, 0);
    chk("reset s_req_wdata", s_req_wdata, 0);
    chk("reset rdata", m0_rsp_rdata | m1_rsp_rdata, 0);
    tick;
    rst = 0;
    tick;
    // IFU-only read, zero-wait slave
    m0_req_valid = 1; m0_req_addr = 32'h8000_0000;
    #1;
    chk("ifu ready", m0_req_ready, 1);
    chk("lsu ready", m1_req_ready, 0);
    tick;
    m0_req_valid = 0; m0_req_addr = 32'h1111_1111;
    chk("ifu N+1 s_req_valid", s_req_valid, 1);
    chk("ifu N+1 s_req_addr", s_req_addr, 32'h8000_0000);
    chk("ifu N+1 s_req_wen", s_req_wen, 0);
    tick;
    chk("ifu N+2 s_rsp_ready", s_rsp_ready, 1);
    s_rsp_valid = 1; s_rsp_rdata = 32'h0000_0413;
    tick;
    s_rsp_valid = 0; s_rsp_rdata = 0;
    chk("ifu N+3 m0_rsp_valid", m0_rsp_valid, 1);
    chk("ifu N+3 m0_rsp_rdata", m0_rsp_rdata, 32'h0000_0413);
    chk("ifu N+3 m0_rsp_err", m0_rsp_err, 0);
    chk("ifu N+3 m1 outputs", {m1_rsp_valid, m1_rsp_err, m1_rsp_rdata}, 0);
    tick;
    chk("ifu N+4 idle", {m0_rsp_valid, s_req_valid, s_rsp_ready}, 0);
    m1_req_valid = 1;
    #1;
    chk("ifu N+4 accepts again", m1_req_ready, 1);
    m1_req_valid = 0;
    // round-robin alternation from a fresh reset
    rst = 1;
    tick;
    rst = 0;
    m0_req_valid = 1; m0_req_addr = 32'h0000_1000;
    m1_req_valid = 1; m1_req_addr = 32'h0000_2000;
    xact(0, 32'h0000_1000, 32'hA0A0_0001, 0, "rr0");
    xact(1, 32'h0000_2000, 32'hB0B0_0002, 0, "rr1");
    xact(0, 32'h0000_1000, 32'hA0A0_0003, 0, "rr2");
    xact(1, 32'h0000_2000, 32'hB0B0_0004, 0, "rr3");
    m0_req_valid = 0; m1_req_valid = 0;
    // LSU write with slave request stall of 3 cycles
    s_req_ready = 0;
    m1_req_valid = 1; m1_req_wen = 1; m1_req_addr = 32'h8000_0100;
    m1_req_wdata = 32'hDEAD_BEEF; m1_req_wstrb = 4'hF;
    #1;
    chk("wr ready", m1_req_ready, 1);
    tick;
    m1_req_valid = 0; m1_req_wen = 0; m1_req_addr = 0; m1_req_wdata = 0; m1_req_wstrb = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) s_req_ready = 1;
      #1;
      chk("wr hold valid", s_req_valid, 1);
      chk("wr hold addr", s_req_addr, 32'h8000_0100);
      chk("wr hold wdata", s_req_wdata, 32'hDEAD_BEEF);
      chk("wr hold wstrb+wen", {s_req_wstrb, s_req_wen}, 5'h1F);
      tick;
    end
    chk("wr in WAIT", {s_req_valid, s_rsp_ready}, 2'b01);
    s_rsp_valid = 1; s_rsp_rdata = 0;
    tick;
    s_rsp_valid = 0;
    chk("wr m1_rsp_valid", m1_rsp_valid, 1);
    chk("wr m1 rdata+err", {m1_rsp_rdata, m1_rsp_err}, 0);
    chk("wr m0_rsp_valid", m0_rsp_valid, 0);
    tick;
    // LSU read with slave error and master response stall of 5 cycles
    m1_rsp_ready = 0;
    m1_req_valid = 1; m1_req_addr = 32'h8000_0200;
    tick;
    m1_req_valid = 0;
    tick;
    s_rsp_valid = 1; s_rsp_rdata = 32'h0000_00AB; s_rsp_err = 1;
    tick;
    s_rsp_valid = 0; s_rsp_rdata = 0; s_rsp_err = 0;
    for (int i = 0; i < 5; i++) begin
      chk("err hold valid", m1_rsp_valid, 1);
      chk("err hold err", m1_rsp_err, 1);
      chk("err hold rdata", m1_rsp_rdata, 32'h0000_00AB);
      tick;
    end
    m1_rsp_ready = 1;
    #1;
    chk("err still RESP", m1_rsp_valid, 1);
    tick;
    chk("err idle", {m1_rsp_valid, s_req_valid, s_rsp_ready}, 0);
    // reset asserted in WAIT
    m0_req_valid = 1; m0_req_addr = 32'h8000_0300;
    tick;
    m0_req_valid = 0;
    tick;
    chk("rst pre s_rsp_ready", s_rsp_ready, 1);
    rst = 1;
    #1;
    chk("rst async outputs", {s_rsp_ready, s_req_valid, m0_rsp_valid, m1_rsp_valid}, 0);
    chk("rst async s_req_addr", s_req_addr, 0);
    tick;
    rst = 0;
    s_rsp_valid = 1; s_rsp_rdata = 32'h5555_5555;
    #1;
    chk("late rsp ignored", s_rsp_ready, 0);
    tick;
    chk("no rsp after reset", {m0_rsp_valid, m1_rsp_valid, s_req_valid}, 0);
    s_rsp_valid = 0; s_rsp_rdata = 0;
    m0_req_valid = 1; m0_req_addr = 32'h8000_0004;
    xact(0, 32'h8000_0004, 32'h0000_0093, 0, "post-rst");
    m0_req_valid = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
